// File: rtl/serial_cmp_pkg.sv
// ============================================================================
// Module      : serial_cmp_pkg
// Description : Shared types for the serial word comparator (state, result).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_cmp_pkg;

    // One-hot word decision; bit order matches {lt, eq, gt}
    typedef enum logic [2:0] {
        ST_LESS    = 3'b100,
        ST_EQUAL   = 3'b010,
        ST_GREATER = 3'b001
    } cmp_state_t;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_result_t;

    localparam cmp_result_t c_RESULT_RESET = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    function automatic cmp_result_t state_to_result(input cmp_state_t s);
        cmp_result_t r;
        r.lt = (s == ST_LESS);
        r.eq = (s == ST_EQUAL);
        r.gt = (s == ST_GREATER);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_comparator_digit_compare.sv
// ============================================================================
// Module      : digit_compare
// Description : Unsigned digit magnitude compare with optional top-bit flip.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module digit_compare #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] i_a,
    input  logic [DIGIT_W-1:0] i_b,
    input  logic               invert_msb,
    output logic               lt,
    output logic               gt
);

    logic [DIGIT_W-1:0] w_a;
    logic [DIGIT_W-1:0] w_b;

    // Flipping the sign bit maps two's-complement order onto unsigned order
    always_comb begin
        w_a              = i_a;
        w_b              = i_b;
        w_a[DIGIT_W-1]   = i_a[DIGIT_W-1] ^ invert_msb;
        w_b[DIGIT_W-1]   = i_b[DIGIT_W-1] ^ invert_msb;
    end

    assign lt = (w_a < w_b);
    assign gt = (w_a > w_b);

endmodule

`default_nettype wire

// File: rtl/serial_word_comparator.sv
// ============================================================================
// Module      : serial_word_comparator
// Description : Digit-serial magnitude comparator of two multi-beat words.
//               Define SERIAL_WORD_CMP_SIGNED_EN for two's-complement compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_word_comparator
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W    = 1,
    parameter int WORD_BEATS = 8,
    parameter int MSB_FIRST  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [DIGIT_W-1:0]          a_digit,
    input  logic [DIGIT_W-1:0]          b_digit,
    output logic                        out_valid,
    output logic                        a_less_b,
    output logic                        a_eq_b,
    output logic                        a_greater_b,
    output logic [((WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1)-1:0] beat_idx
);

    localparam int IDX_W = (WORD_BEATS > 1) ? $clog2(WORD_BEATS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_BEAT = IDX_W'(WORD_BEATS - 1);

    cmp_state_t        r_state;
    cmp_state_t        w_next_state;
    logic [IDX_W-1:0]  r_beat_idx;
    logic              r_out_valid;
    cmp_result_t       r_result;

    logic              w_accept;
    logic              w_last_beat;
    logic              w_invert_msb;
    logic              w_lt;
    logic              w_gt;

    assign w_accept    = in_valid & ~flush;
    assign w_last_beat = (r_beat_idx == c_LAST_BEAT);

`ifdef SERIAL_WORD_CMP_SIGNED_EN
    localparam logic [IDX_W-1:0] c_MS_BEAT = (MSB_FIRST != 0) ? {IDX_W{1'b0}} : c_LAST_BEAT;
    assign w_invert_msb = (r_beat_idx == c_MS_BEAT);
`else
    assign w_invert_msb = 1'b0;
`endif

    digit_compare #(
        .DIGIT_W    (DIGIT_W)
    ) u_digit_compare (
        .i_a        (a_digit),
        .i_b        (b_digit),
        .invert_msb (w_invert_msb),
        .lt         (w_lt),
        .gt         (w_gt)
    );

    // MSB-first locks on the first difference; LSB-first lets later beats override
    always_comb begin
        w_next_state = r_state;
        if (MSB_FIRST != 0) begin
            if (r_state == ST_EQUAL) begin
                if (w_lt)      w_next_state = ST_LESS;
                else if (w_gt) w_next_state = ST_GREATER;
            end
        end else begin
            if (w_lt)      w_next_state = ST_LESS;
            else if (w_gt) w_next_state = ST_GREATER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EQUAL;
            r_beat_idx  <= {IDX_W{1'b0}};
            r_out_valid <= 1'b0;
            r_result    <= c_RESULT_RESET;
        end else begin
            r_out_valid <= 1'b0;
            if (flush) begin
                r_state    <= ST_EQUAL;
                r_beat_idx <= {IDX_W{1'b0}};
            end else if (w_accept) begin
                if (w_last_beat) begin
                    r_state     <= ST_EQUAL;
                    r_beat_idx  <= {IDX_W{1'b0}};
                    r_out_valid <= 1'b1;
                    r_result    <= state_to_result(w_next_state);
                end else begin
                    r_state    <= w_next_state;
                    r_beat_idx <= r_beat_idx + IDX_W'(1);
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign a_less_b    = r_result.lt;
    assign a_eq_b      = r_result.eq;
    assign a_greater_b = r_result.gt;
    assign beat_idx    = r_beat_idx;

endmodule

`default_nettype wire

// File: tb/tb_serial_word_comparator.sv
// ============================================================================
// Module      : tb_serial_word_comparator
// Description : Self-checking bench: directed vector table plus random traffic
//               against a word-level reference model, three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_word_comparator;

    localparam logic [2:0] c_LT = 3'b100;
    localparam logic [2:0] c_EQ = 3'b010;
    localparam logic [2:0] c_GT = 3'b001;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic       fl0, iv0, ov0, lt0, eq0, gt0;
    logic [0:0] a0, b0;
    logic [2:0] bi0;
    logic       fl1, iv1, ov1, lt1, eq1, gt1;
    logic [3:0] a1, b1;
    logic [0:0] bi1;
    logic       fl2, iv2, ov2, lt2, eq2, gt2;
    logic [7:0] a2, b2;
    logic [0:0] bi2;

    serial_word_comparator #(.DIGIT_W(1), .WORD_BEATS(8), .MSB_FIRST(1)) u_dut0 (
        .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .a_digit(a0), .b_digit(b0),
        .out_valid(ov0), .a_less_b(lt0), .a_eq_b(eq0), .a_greater_b(gt0), .beat_idx(bi0));

    serial_word_comparator #(.DIGIT_W(4), .WORD_BEATS(2), .MSB_FIRST(0)) u_dut1 (
        .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .a_digit(a1), .b_digit(b1),
        .out_valid(ov1), .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1), .beat_idx(bi1));

    serial_word_comparator #(.DIGIT_W(8), .WORD_BEATS(1), .MSB_FIRST(1)) u_dut2 (
        .clk(clk), .rst(rst), .flush(fl2), .in_valid(iv2), .a_digit(a2), .b_digit(b2),
        .out_valid(ov2), .a_less_b(lt2), .a_eq_b(eq2), .a_greater_b(gt2), .beat_idx(bi2));

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int cfg_dw(input int k);
        return (k == 0) ? 1 : (k == 1) ? 4 : 8;
    endfunction
    function automatic int cfg_wb(input int k);
        return (k == 0) ? 8 : (k == 1) ? 2 : 1;
    endfunction
    function automatic int cfg_mf(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    task automatic drive(input int k, input logic iv, input logic fl,
                         input logic [7:0] a, input logic [7:0] b);
        case (k)
            0: begin iv0 = iv; fl0 = fl; a0 = a[0:0]; b0 = b[0:0]; end
            1: begin iv1 = iv; fl1 = fl; a1 = a[3:0]; b1 = b[3:0]; end
            default: begin iv2 = iv; fl2 = fl; a2 = a; b2 = b; end
        endcase
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) drive(k, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic sample(input int k, output logic ov, output logic [2:0] res, output int bi);
        case (k)
            0: begin ov = ov0; res = {lt0, eq0, gt0}; bi = int'(bi0); end
            1: begin ov = ov1; res = {lt1, eq1, gt1}; bi = int'(bi1); end
            default: begin ov = ov2; res = {lt2, eq2, gt2}; bi = int'(bi2); end
        endcase
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d", name, got, exp);
    endtask

    // ---------------- word-level reference model ----------------
    int                m_cnt [3];
    longint unsigned   m_a   [3];
    longint unsigned   m_b   [3];
    logic              m_ev  [3];
    logic [2:0]        m_res [3];

    function automatic logic [2:0] word_cmp(input longint unsigned a, input longint unsigned b,
                                            input int w);
        longint sa;
        longint sb;
        sa = longint'(a);
        sb = longint'(b);
`ifdef SERIAL_WORD_CMP_SIGNED_EN
        if (((a >> (w - 1)) & 64'd1) != 0) sa = sa - (longint'(1) << w);
        if (((b >> (w - 1)) & 64'd1) != 0) sb = sb - (longint'(1) << w);
`endif
        if (sa < sb)      return c_LT;
        else if (sa > sb) return c_GT;
        else              return c_EQ;
    endfunction

    task automatic model_step(input int k, input logic r, input logic fl, input logic iv,
                              input logic [7:0] a, input logic [7:0] b);
        int dw;
        int wb;
        dw = cfg_dw(k);
        wb = cfg_wb(k);
        if (r) begin
            m_cnt[k] = 0; m_a[k] = 0; m_b[k] = 0; m_ev[k] = 1'b0; m_res[k] = c_EQ;
        end else begin
            m_ev[k] = 1'b0;
            if (fl) begin
                m_cnt[k] = 0; m_a[k] = 0; m_b[k] = 0;
            end else if (iv) begin
                if (cfg_mf(k) != 0) begin
                    m_a[k] = (m_a[k] << dw) | 64'(a);
                    m_b[k] = (m_b[k] << dw) | 64'(b);
                end else begin
                    m_a[k] = m_a[k] | (64'(a) << (dw * m_cnt[k]));
                    m_b[k] = m_b[k] | (64'(b) << (dw * m_cnt[k]));
                end
                m_cnt[k]++;
                if (m_cnt[k] == wb) begin
                    m_ev[k]  = 1'b1;
                    m_res[k] = word_cmp(m_a[k], m_b[k], dw * wb);
                    m_cnt[k] = 0; m_a[k] = 0; m_b[k] = 0;
                end
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         dut;
        logic       r;
        logic       f;
        logic       iv;
        logic [7:0] a;
        logic [7:0] b;
        logic       ev;
        logic [2:0] res;
        int         bidx;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int k, input logic r, input logic f, input logic iv,
                                input logic [7:0] a, input logic [7:0] b,
                                input logic ev, input logic [2:0] res, input int bidx);
        vec_t v;
        v.dut = k; v.r = r; v.f = f; v.iv = iv; v.a = a; v.b = b;
        v.ev = ev; v.res = res; v.bidx = bidx;
        vecs.push_back(v);
    endfunction

    function automatic logic [7:0] digit_of(input int k, input logic [7:0] w, input int i);
        int pos;
        int t;
        pos = (cfg_mf(k) != 0) ? (cfg_wb(k) - 1 - i) : i;
        t   = int'(w) >> (pos * cfg_dw(k));
        return 8'(t & ((1 << cfg_dw(k)) - 1));
    endfunction

    // Adds one full word; flags show `held` until the final beat, then `fin`
    function automatic void add_word(input int k, input logic [7:0] aw, input logic [7:0] bw,
                                     input logic [2:0] held, input logic [2:0] fin,
                                     input int gap_after, input int gap_len);
        int wb;
        wb = cfg_wb(k);
        for (int i = 0; i < wb; i++) begin
            if (i == wb - 1)
                add(k, 1'b0, 1'b0, 1'b1, digit_of(k, aw, i), digit_of(k, bw, i), 1'b1, fin, 0);
            else
                add(k, 1'b0, 1'b0, 1'b1, digit_of(k, aw, i), digit_of(k, bw, i), 1'b0, held, i + 1);
            if (i == gap_after)
                for (int g = 0; g < gap_len; g++)
                    add(k, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, held, i + 1);
        end
    endfunction

    initial begin
        logic       ov;
        logic [2:0] res;
        int         bi;
        logic [2:0] s5a;
        logic [2:0] s5b;
        logic       r;
        logic       fl [3];
        logic       iv [3];
        logic [7:0] ra [3];
        logic [7:0] rb [3];

`ifdef SERIAL_WORD_CMP_SIGNED_EN
        s5a = c_LT; s5b = c_GT;
`else
        s5a = c_GT; s5b = c_LT;
`endif
        rst = 1'b1;
        idle_all();

        // reset state, rst overriding in_valid
        add(0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, c_EQ, 0);
        add(1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_EQ, 0);
        add(2, 1'b1, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, c_EQ, 0);
        // 0x5A vs 0x59, bit-serial MSB first
        add_word(0, 8'h5A, 8'h59, c_EQ, c_GT, -1, 0);
        add(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_GT, 0);
        // rst mid-word, then a word that must start clean
        for (int i = 0; i < 4; i++) add(0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, c_GT, i + 1);
        add(0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, c_EQ, 0);
        add(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_EQ, 0);
        add_word(0, 8'h01, 8'h02, c_EQ, c_LT, -1, 0);
        // back-to-back equal then less, with gaps
        add_word(0, 8'h3C, 8'h3C, c_LT, c_EQ, 2, 2);
        add_word(0, 8'h10, 8'h20, c_EQ, c_LT, 5, 1);
        add(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_LT, 0);
        // flush after 3 beats of a greater word (with a discarded beat), then equal word
        for (int i = 0; i < 3; i++) add(0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 1'b0, c_LT, i + 1);
        add(0, 1'b0, 1'b1, 1'b1, 8'h01, 8'h00, 1'b0, c_LT, 0);
        add_word(0, 8'hAA, 8'hAA, c_LT, c_EQ, -1, 0);
        add(0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_EQ, 0);
        // LSB-first nibbles: high nibble overrides
        add_word(1, 8'h1F, 8'h2E, c_EQ, c_LT, -1, 0);
        add(1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_LT, 0);
        add_word(1, 8'h2E, 8'h1F, c_LT, c_GT, -1, 0);
        // single-beat words, signed vs unsigned
        add(2, 1'b0, 1'b0, 1'b1, 8'h80, 8'h01, 1'b1, s5a, 0);
        add(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, s5a, 0);
        add(2, 1'b0, 1'b0, 1'b1, 8'h7F, 8'hFF, 1'b1, s5b, 0);
        add(2, 1'b0, 1'b0, 1'b1, 8'h42, 8'h42, 1'b1, c_EQ, 0);
        add(2, 1'b0, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, c_EQ, 0);
        add(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, c_EQ, 0);

        foreach (vecs[i]) begin
            rst = vecs[i].r;
            idle_all();
            drive(vecs[i].dut, vecs[i].iv, vecs[i].f, vecs[i].a, vecs[i].b);
            @(posedge clk);
            #1;
            sample(vecs[i].dut, ov, res, bi);
            check($sformatf("vec%0d_dut%0d_out_valid", i, vecs[i].dut), int'(ov), int'(vecs[i].ev));
            check($sformatf("vec%0d_dut%0d_flags", i, vecs[i].dut), int'(res), int'(vecs[i].res));
            check($sformatf("vec%0d_dut%0d_beat_idx", i, vecs[i].dut), bi, vecs[i].bidx);
        end

        // randomized traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = (cyc == 0) || ($urandom_range(0, 199) == 0);
            for (int k = 0; k < 3; k++) begin
                logic [7:0] mask;
                mask  = 8'((1 << cfg_dw(k)) - 1);
                iv[k] = ($urandom_range(0, 9) < 7);
                fl[k] = ($urandom_range(0, 19) == 0);
                ra[k] = 8'($urandom) & mask;
                rb[k] = ($urandom_range(0, 1) == 0) ? ra[k] : (8'($urandom) & mask);
                drive(k, iv[k], fl[k], ra[k], rb[k]);
            end
            rst = r;
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++) begin
                model_step(k, r, fl[k], iv[k], ra[k], rb[k]);
                sample(k, ov, res, bi);
                check($sformatf("rand%0d_dut%0d_out_valid", cyc, k), int'(ov), int'(m_ev[k]));
                check($sformatf("rand%0d_dut%0d_flags", cyc, k), int'(res), int'(m_res[k]));
                check($sformatf("rand%0d_dut%0d_beat_idx", cyc, k), bi, m_cnt[k]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_word_comparator.md
SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 1, meaning bits of each operand per beat (>=1).
REQ-002 The block SHALL have parameter WORD_BEATS, default 8, meaning beats per word (>=1).
REQ-003 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = most significant digit first and 0 = least significant digit first.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all logic on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush, input, 1 bit: abort the current word and restart at beat 0.
REQ-007 The block SHALL have port in_valid, input, 1 bit: a_digit/b_digit carry a beat this cycle.
REQ-008 The block SHALL have ports a_digit and b_digit, input, DIGIT_W bits each: the operand digits.
REQ-009 The block SHALL have port out_valid, output, 1 bit: one-cycle pulse when a word result is presented.
REQ-010 The block SHALL have ports a_less_b, a_eq_b and a_greater_b, output, 1 bit each: last word result, one-hot.
REQ-011 The block SHALL have port beat_idx, output, $clog2(WORD_BEATS) bits (min 1): the index of the next beat expected.

Function
REQ-012 A beat SHALL be accepted only when in_valid=1 and flush=0.
- No accepted beat: word state and beat_idx hold.
REQ-013 The word FSM SHALL have states ST_EQUAL, ST_LESS and ST_GREATER, and SHALL enter ST_EQUAL at word start.
REQ-014 Per accepted beat, digit comparison SHALL treat digits as unsigned DIGIT_W values, except as modified by REQ-024.
REQ-015 When MSB_FIRST=1, the FSM SHALL leave ST_EQUAL on the first unequal beat and hold ST_LESS/ST_GREATER for the rest of the word.
REQ-016 When MSB_FIRST=0, any unequal beat SHALL move the FSM to ST_LESS/ST_GREATER (overriding the prior state), and an equal beat SHALL keep the state.
REQ-017 beat_idx SHALL increment per accepted beat and wrap WORD_BEATS-1 -> 0.
REQ-018 On acceptance of beat WORD_BEATS-1, the next cycle SHALL give out_valid=1 with result flags equal to the final decision including that beat.
- Latency: 1 cycle from the last beat.
REQ-019 The word FSM SHALL return to ST_EQUAL in the same edge as REQ-018, so back-to-back words are accepted without a bubble.
REQ-020 Result flags SHALL be registered and held between out_valid pulses; out_valid SHALL be high for exactly one cycle per completed word.
REQ-021 flush=1 SHALL set beat_idx to 0 and the FSM to ST_EQUAL, discard any simultaneous beat, and produce no out_valid.
- Previously presented result flags are unchanged.
REQ-022 When WORD_BEATS=1, every accepted beat SHALL produce a result on the next cycle.

Reset
REQ-023 On rst=1, the next state SHALL be:
- FSM ST_EQUAL; beat_idx 0; out_valid 0.
- a_eq_b 1; a_less_b 0; a_greater_b 0.
- rst overrides flush and in_valid.
- rst mid-word discards the partial word.

Configuration
REQ-024 When macro SERIAL_WORD_CMP_SIGNED_EN is defined, the operands SHALL be compared as two's-complement words by inverting the top bit of both digits in the most significant beat before comparison.
- Most significant beat: beat 0 if MSB_FIRST=1, beat WORD_BEATS-1 if MSB_FIRST=0.
- Without the macro, the comparison SHALL be purely unsigned.

Structure
REQ-025 Package serial_cmp_pkg SHALL hold the one-hot state enum (ST_LESS=3'b100, ST_EQUAL=3'b010, ST_GREATER=3'b001) and a result typedef.
REQ-026 Combinational sub-module digit_compare (DIGIT_W, invert_msb input; outputs lt, gt) SHALL be instantiated once.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- DIGIT_W=1, WORD_BEATS=8, MSB_FIRST=1, a=0x5A, b=0x59 -> out_valid 1 cycle after the 8th beat, a_greater_b=1.
- MSB_FIRST=0, DIGIT_W=4, WORD_BEATS=2, a=0x1F, b=0x2E (low nibble first) -> a_less_b=1 (high nibble overrides).
- Back-to-back words equal then a<b, in_valid gaps inserted mid-word -> two pulses, a_eq_b then a_less_b, beat_idx held during gaps.
- flush after 3 beats of an a>b word, then a fresh equal word -> no pulse for the aborted word, next pulse a_eq_b=1.
- SIGNED_EN, DIGIT_W=8, WORD_BEATS=1, a=0x80, b=0x01 -> a_less_b=1; same stimulus without the macro -> a_greater_b=1.
- rst asserted mid-word -> outputs at reset values next cycle, beat_idx=0, no out_valid.
